// File: rtl/game_tick_gen.sv
// Game tick generator: turns rising edges of a slow divider bit into one-cycle
// game-advance pulses, with a speed ramp, pause/crash handling and a tick counter.
//
// state  | meaning
// IDLE   | powered up, waiting for start
// RUN    | counting divider edges, issuing ticks, ramping speed
// PAUSED | all counters frozen, edges discarded
// OVER   | game ended, counters held for readout until start
module game_tick_gen #(
   parameter int unsigned INIT_PERIOD = 16,
   parameter int unsigned MIN_PERIOD  = 4,
   parameter int unsigned RAMP_TICKS  = 64,
   parameter int unsigned STEP        = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_in,
   input  logic        start,
   input  logic        pause,
   input  logic        crash,
   output logic        tick,
   output logic [7:0]  period,
   output logic [15:0] tick_count,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSED = 2'b10,
      OVER   = 2'b11
   } state_t;

   localparam logic [7:0]  INIT_P    = 8'(INIT_PERIOD);
   localparam logic [8:0]  MIN_P     = 9'(MIN_PERIOD);
   localparam logic [8:0]  STEP_P    = 9'(STEP);
   localparam logic [15:0] RAMP_LAST = 16'(RAMP_TICKS - 1);

   state_t      st;
   logic        sync1, sync2, sync3;
   logic [2:0]  warm;
   logic        edge_q;
   logic [7:0]  edge_cnt;
   logic [15:0] ramp_cnt;
   logic [8:0]  period_wide;
   logic [7:0]  ramped;
   logic        edge_last;

   assign state = st;

   // warm keeps the reset value of sync3 from masquerading as a low sample,
   // so div_in already high at reset release is not seen as a rising edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync3  <= 1'b0;
         warm   <= 3'b000;
         edge_q <= 1'b0;
      end else begin
         sync1  <= div_in;
         sync2  <= sync1;
         sync3  <= sync2;
         warm   <= {warm[1:0], 1'b1};
         edge_q <= sync2 & ~sync3 & warm[2];
      end
   end

   always_comb begin
      period_wide = {1'b0, period};
      ramped      = period;
      if (period_wide >= MIN_P + STEP_P) begin
         ramped = 8'(period_wide - STEP_P);
      end else begin
         ramped = MIN_P[7:0];
      end
   end

   assign edge_last = (edge_cnt == period - 8'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st         <= IDLE;
         tick       <= 1'b0;
         period     <= INIT_P;
         tick_count <= 16'd0;
         edge_cnt   <= 8'd0;
         ramp_cnt   <= 16'd0;
      end else begin
         tick <= 1'b0;
         case (st)
            IDLE, OVER: begin
               if (start) begin
                  st         <= RUN;
                  period     <= INIT_P;
                  tick_count <= 16'd0;
                  edge_cnt   <= 8'd0;
                  ramp_cnt   <= 16'd0;
               end
            end
            RUN: begin
               // leaving RUN swallows any edge arriving in the same cycle
               if (crash) begin
                  st <= OVER;
               end else if (pause) begin
                  st <= PAUSED;
               end else if (edge_q) begin
                  if (edge_last) begin
                     edge_cnt   <= 8'd0;
                     tick       <= 1'b1;
                     tick_count <= tick_count + 16'd1;
                     if (ramp_cnt == RAMP_LAST) begin
                        ramp_cnt <= 16'd0;
                        period   <= ramped;
                     end else begin
                        ramp_cnt <= ramp_cnt + 16'd1;
                     end
                  end else begin
                     edge_cnt <= edge_cnt + 8'd1;
                  end
               end
            end
            PAUSED: begin
               if (crash) begin
                  st <= OVER;
               end else if (!pause) begin
                  st <= RUN;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_game_tick_gen.sv
// Bench for game_tick_gen: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a behavioural model.
module tb_game_tick_gen;

   localparam int INIT_P = 16;
   localparam int MIN_P  = 4;
   localparam int RAMP_T = 4;
   localparam int STEP_P = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        div_in = 1'b0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        crash = 1'b0;
   logic        tick;
   logic [7:0]  period;
   logic [15:0] tick_count;
   logic [1:0]  state;

   always #5 clk = ~clk;

   game_tick_gen #(
      .INIT_PERIOD(INIT_P),
      .MIN_PERIOD (MIN_P),
      .RAMP_TICKS (RAMP_T),
      .STEP       (STEP_P)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .div_in    (div_in),
      .start     (start),
      .pause     (pause),
      .crash     (crash),
      .tick      (tick),
      .period    (period),
      .tick_count(tick_count),
      .state     (state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [1:0]  st;
      logic        tk;
      logic [7:0]  per;
      logic [7:0]  ecnt;
      logic [15:0] rcnt;
      logic [15:0] tc;
   } mdl_t;

   localparam mdl_t M_RESET = '{st: 2'd0, tk: 1'b0, per: 8'(INIT_P), ecnt: 8'd0,
                                rcnt: 16'd0, tc: 16'd0};

   function automatic mdl_t mstep(input mdl_t m, input logic ev, input logic s,
                                  input logic p, input logic c);
      mdl_t n;
      int   np;
      n    = m;
      n.tk = 1'b0;
      case (m.st)
         2'd0, 2'd3: begin
            if (s) begin
               n.st   = 2'd1;
               n.per  = 8'(INIT_P);
               n.ecnt = 8'd0;
               n.rcnt = 16'd0;
               n.tc   = 16'd0;
            end
         end
         2'd1: begin
            if (c) n.st = 2'd3;
            else if (p) n.st = 2'd2;
            else if (ev) begin
               if (int'(m.ecnt) + 1 == int'(m.per)) begin
                  n.ecnt = 8'd0;
                  n.tk   = 1'b1;
                  n.tc   = 16'((int'(m.tc) + 1) % 65536);
                  if (int'(m.rcnt) + 1 == RAMP_T) begin
                     n.rcnt = 16'd0;
                     np     = int'(m.per) - STEP_P;
                     n.per  = 8'((np < MIN_P) ? MIN_P : np);
                  end else begin
                     n.rcnt = m.rcnt + 16'd1;
                  end
               end else begin
                  n.ecnt = m.ecnt + 8'd1;
               end
            end
         end
         default: begin
            if (c) n.st = 2'd3;
            else if (!p) n.st = 2'd1;
         end
      endcase
      return n;
   endfunction

   // hist[i] is the div_in sample taken i+1 clocks ago; an edge reaches the
   // game logic three clocks after the rising sample, and only once four
   // post-reset samples exist
   mdl_t     m = M_RESET;
   logic [3:0] hist = 4'b0;
   int       nsamp = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m     <= M_RESET;
         hist  <= 4'b0;
         nsamp <= 0;
      end else begin
         m    <= mstep(m, (nsamp >= 4) && hist[2] && !hist[3], start, pause, crash);
         hist <= {hist[2:0], div_in};
         if (nsamp < 4) nsamp <= nsamp + 1;
      end
   end

   always @(negedge clk) begin
      chk("state", 32'(state), 32'(m.st));
      chk("tick", 32'(tick), 32'(m.tk));
      chk("period", 32'(period), 32'(m.per));
      chk("tick_count", 32'(tick_count), 32'(m.tc));
   end

   // ---------------- directed + random stimulus ----------------
   int ncyc = 0;
   int ticks_seen = 0;
   int tick_cyc = 0;
   int tick_tc = 0;
   int tick_per = 0;

   task automatic tk();
      @(negedge clk);
      ncyc++;
      if (tick === 1'b1) begin
         ticks_seen++;
         tick_cyc = ncyc;
         tick_tc  = int'(tick_count);
         tick_per = int'(period);
      end
   endtask

   task automatic rise_fall(input int half, output int rise_at);
      div_in  = 1'b1;
      rise_at = ncyc;
      repeat (half) tk();
      div_in = 1'b0;
      repeat (half) tk();
   endtask

   initial begin
      int rise_at;
      int prev_tick;
      int pre_ticks;
      int pre_tc;
      int g;
      int exp_per[4];
      exp_per = '{11, 6, 4, 4};

      // reset values
      repeat (3) tk();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_period", 32'(period), 32'd16);
      chk("rst_tick_count", 32'(tick_count), 32'd0);
      rst = 1'b1;
      repeat (5) tk();
      chk("idle_hold", 32'(state), 32'd0);

      // start; div_in rises every 8 clk -> tick every 128 clk
      start = 1'b1;
      tk();
      start = 1'b0;
      chk("start_run", 32'(state), 32'd1);
      prev_tick = 0;
      for (int k = 1; k <= 3; k++) begin
         for (int r = 0; r < 16; r++) rise_fall(4, rise_at);
         chk("tick_latency", 32'(tick_cyc), 32'(rise_at + 4));
         chk("tick_number", 32'(ticks_seen), 32'(k));
         chk("tick_count_seq", 32'(tick_tc), 32'(k));
         chk("tick_period16", 32'(tick_per), 32'd16);
         if (k > 1) chk("tick_interval", 32'(tick_cyc - prev_tick), 32'd128);
         prev_tick = tick_cyc;
      end

      // ramp: every 4th tick period drops by 5, floored at 4
      for (int ms = 0; ms < 4; ms++) begin
         g = 0;
         while (ticks_seen < (ms + 1) * RAMP_T && g < 100) begin
            rise_fall(4, rise_at);
            g++;
         end
         chk("ramp_tick_number", 32'(ticks_seen), 32'((ms + 1) * RAMP_T));
         chk("ramp_period", 32'(tick_per), 32'(exp_per[ms]));
      end

      // crash+pause together on the terminal edge (period 4, edge_cnt 3)
      pre_tc    = int'(tick_count);
      pre_ticks = ticks_seen;
      repeat (3) rise_fall(4, rise_at);
      div_in = 1'b1;
      repeat (3) tk();
      crash = 1'b1;
      pause = 1'b1;
      tk();
      crash = 1'b0;
      pause = 1'b0;
      chk("crash_state", 32'(state), 32'd3);
      div_in = 1'b0;
      repeat (3) rise_fall(4, rise_at);
      chk("crash_no_tick", 32'(ticks_seen), 32'(pre_ticks));
      chk("crash_tc_frozen", 32'(tick_count), 32'(pre_tc));
      start = 1'b1;
      tk();
      start = 1'b0;
      chk("restart_state", 32'(state), 32'd1);
      chk("restart_period", 32'(period), 32'd16);
      chk("restart_tc", 32'(tick_count), 32'd0);

      // pause for 500 clk with edge_cnt at 7, edges keep arriving meanwhile
      repeat (7) rise_fall(4, rise_at);
      pre_ticks = ticks_seen;
      pause = 1'b1;
      repeat (60) rise_fall(4, rise_at);
      repeat (20) tk();
      chk("pause_state", 32'(state), 32'd2);
      chk("pause_no_tick", 32'(ticks_seen), 32'(pre_ticks));
      pause = 1'b0;
      tk();
      chk("resume_state", 32'(state), 32'd1);
      repeat (8) rise_fall(4, rise_at);
      chk("resume_8_edges", 32'(ticks_seen), 32'(pre_ticks));
      rise_fall(4, rise_at);
      chk("resume_9th_edge", 32'(ticks_seen), 32'(pre_ticks + 1));
      chk("resume_latency", 32'(tick_cyc), 32'(rise_at + 4));

      // reset mid-RUN with div_in high
      div_in = 1'b1;
      repeat (2) tk();
      #2 rst = 1'b0;
      #1;
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_tick", 32'(tick), 32'd0);
      repeat (4) tk();
      rst = 1'b1;
      pre_ticks = ticks_seen;
      repeat (10) tk();
      repeat (4) rise_fall(4, rise_at);
      chk("post_rst_idle", 32'(state), 32'd0);
      chk("post_rst_no_tick", 32'(ticks_seen), 32'(pre_ticks));

      // randomized play
      for (int i = 0; i < 4000; i++) begin
         tk();
         if ($urandom_range(0, 2) == 0) div_in = ~div_in;
         start = ($urandom_range(0, 30) == 0);
         if ($urandom_range(0, 60) == 0) pause = ~pause;
         crash = ($urandom_range(0, 250) == 0);
         if ($urandom_range(0, 1500) == 0) begin
            #2 rst = 1'b0;
            tk();
            tk();
            #2 rst = 1'b1;
         end
      end
      tk();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
